fwft_bram_fifo: RTL and testbench

First-word-fall-through FIFO built on a BRAM-inferable storage array with a synchronous read port. Each traffic endpoint uses one to queue injection requests (packet id, size, destination) while the packet injector is not ready. The head word is always presented on `dout` whenever the FIFO is non-empty; `rd_en` pops it.

---
 rtl/fwft_bram_fifo.sv | 144 ++++++++++++++
 tb/tb_fwft_bram_fifo.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/fwft_bram_fifo.sv
// +--------------------------------------------------------------------------+
// | fwft_bram_fifo: first-word-fall-through FIFO on a BRAM-style array       |
// | with a registered read port; head word always presented on dout.         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module fwft_bram_fifo #(
    parameter int    DATA_WIDTH                    = 32,
    parameter int    MAX_DEPTH                     = 256,
    parameter string IGNORE_SAME_LOC_RD_WR_WARNING = "NO"
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  wr_en,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  full,
    output logic                  nearly_full,
    output logic                  recieve_more_than_0,
    output logic                  recieve_more_than_1
);

    localparam int C_PTR_W = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1;
    localparam int C_CNT_W = $clog2(MAX_DEPTH + 1);

    localparam logic [C_PTR_W-1:0] C_PTR_LAST = C_PTR_W'(MAX_DEPTH - 1);
    localparam logic [C_PTR_W-1:0] C_PTR_ONE  = C_PTR_W'(1);
    localparam logic [C_CNT_W-1:0] C_CNT_MAX  = C_CNT_W'(MAX_DEPTH);
    localparam logic [C_CNT_W-1:0] C_CNT_NF   = C_CNT_W'(MAX_DEPTH - 1);
    localparam logic [C_CNT_W-1:0] C_CNT_ONE  = C_CNT_W'(1);
    localparam logic [C_CNT_W-1:0] C_CNT_TWO  = C_CNT_W'(2);

    logic [DATA_WIDTH-1:0] mem [0:MAX_DEPTH-1];
    logic [DATA_WIDTH-1:0] ram_rd_q;

    logic [C_PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [C_PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [C_CNT_W-1:0]    count_q, count_d;
    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic                  use_ram_q, use_ram_d;

    logic                  w_eff_rd;
    logic                  w_eff_wr;
    logic                  w_bypass;
    logic                  w_prefetch;
    logic [C_PTR_W-1:0]    w_wr_ptr_inc;
    logic [C_PTR_W-1:0]    w_rd_ptr_inc;

    assign w_eff_rd     = rd_en && (count_q != '0);
    assign w_eff_wr     = wr_en && ((count_q != C_CNT_MAX) || w_eff_rd);
    // A word entering an otherwise-empty head slot skips the storage read latency.
    assign w_bypass     = w_eff_wr && ((count_q == '0) || ((count_q == C_CNT_ONE) && w_eff_rd));
    assign w_prefetch   = w_eff_rd && (count_q >= C_CNT_TWO);
    assign w_wr_ptr_inc = (wr_ptr_q == C_PTR_LAST) ? '0 : wr_ptr_q + C_PTR_ONE;
    assign w_rd_ptr_inc = (rd_ptr_q == C_PTR_LAST) ? '0 : rd_ptr_q + C_PTR_ONE;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        head_d    = head_q;
        use_ram_d = use_ram_q;

        if (w_eff_wr) begin
            wr_ptr_d = w_wr_ptr_inc;
        end
        if (w_eff_rd) begin
            rd_ptr_d = w_rd_ptr_inc;
        end

        if (w_eff_wr && !w_eff_rd) begin
            count_d = count_q + C_CNT_ONE;
        end else if (!w_eff_wr && w_eff_rd) begin
            count_d = count_q - C_CNT_ONE;
        end

        // Draining the last word touches neither source, so dout keeps its value.
        if (w_bypass) begin
            head_d    = din;
            use_ram_d = 1'b0;
        end else if (w_prefetch) begin
            use_ram_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            head_q    <= '0;
            use_ram_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            head_q    <= head_d;
            use_ram_q <= use_ram_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_eff_wr) begin
            mem[wr_ptr_q] <= din;
        end
        if (w_prefetch) begin
            ram_rd_q <= mem[rd_ptr_d];
        end
    end

    assign dout                = use_ram_q ? ram_rd_q : head_q;
    assign full                = (count_q == C_CNT_MAX);
    assign nearly_full         = (count_q >= C_CNT_NF);
    assign recieve_more_than_0 = (count_q != '0);
    assign recieve_more_than_1 = (count_q >= C_CNT_TWO);

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!reset) begin
            if (wr_en && !w_eff_wr) begin
                $display("%m: warning, overflow write ignored at %0t", $time);
            end
            if (rd_en && !w_eff_rd) begin
                $display("%m: warning, underflow read ignored at %0t", $time);
            end
        end
    end

    generate
        if (IGNORE_SAME_LOC_RD_WR_WARNING == "NO") begin : g_same_loc_check
            always @(posedge clk) begin
                if (!reset && w_eff_wr && w_prefetch && (wr_ptr_q == rd_ptr_d)) begin
                    $display("%m: warning, same-location read and write at %0t", $time);
                end
            end
        end
    endgenerate
`endif

endmodule

`default_nettype wire

// File: tb/tb_fwft_bram_fifo.sv
// +--------------------------------------------------------------------------+
// | tb_fwft_bram_fifo: self-checking bench for fwft_bram_fifo (depth 5).     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_fwft_bram_fifo;

    localparam int C_DW    = 32;
    localparam int C_DEPTH = 5;

    logic            clk;
    logic            rst;
    logic [C_DW-1:0] din;
    logic            wr_en;
    logic            rd_en;
    logic [C_DW-1:0] dout;
    logic            full;
    logic            nearly_full;
    logic            rm0;
    logic            rm1;
    logic [3:0]      w_flags;

    assign w_flags = {full, nearly_full, rm1, rm0};

    fwft_bram_fifo #(
        .DATA_WIDTH                    (C_DW),
        .MAX_DEPTH                     (C_DEPTH),
        .IGNORE_SAME_LOC_RD_WR_WARNING ("NO")
    ) dut (
        .clk                 (clk),
        .reset               (rst),
        .din                 (din),
        .wr_en               (wr_en),
        .rd_en               (rd_en),
        .dout                (dout),
        .full                (full),
        .nearly_full         (nearly_full),
        .recieve_more_than_0 (rm0),
        .recieve_more_than_1 (rm1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic            wr;
        logic            rd;
        logic [C_DW-1:0] din;
        logic [C_DW-1:0] exp_dout;
        logic [3:0]      exp_flags;
    } vec_t;

    vec_t vecs[0:31];
    int   n_vecs;
    int   n_pass;
    int   n_checks;

    logic [C_DW-1:0] sb[$];

    task automatic check(input string name, input logic [C_DW-1:0] act, input logic [C_DW-1:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic wr, input logic rd, input logic [C_DW-1:0] d,
                       input logic [C_DW-1:0] ed, input logic [3:0] ef);
        vecs[n_vecs] = '{wr: wr, rd: rd, din: d, exp_dout: ed, exp_flags: ef};
        n_vecs++;
    endtask

    // Inputs are set mid-cycle, one edge is taken, outputs are sampled 1 time unit later.
    task automatic step(input logic wr, input logic rd, input logic [C_DW-1:0] d);
        wr_en = wr;
        rd_en = rd;
        din   = d;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        din   = '0;
    endtask

    task automatic pulse_reset();
        #2;
        rst = 1'b1;
        #1;
        check("async reset dout", dout, '0);
        check("async reset flags", {28'd0, w_flags}, '0);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [C_DW-1:0] model_q[$];
        logic [C_DW-1:0] last_head;
        logic [C_DW-1:0] exp_v;
        logic            wr;
        logic            rd;
        logic            eff_rd;
        logic            eff_wr;
        logic [C_DW-1:0] d;
        int              sz;

        n_pass   = 0;
        n_checks = 0;
        n_vecs   = 0;
        rst      = 1'b1;
        wr_en    = 1'b0;
        rd_en    = 1'b0;
        din      = '0;

        #2;
        check("reset dout", dout, '0);
        check("reset flags", {28'd0, w_flags}, '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("idle after reset flags", {28'd0, w_flags}, '0);

        // flags = {full, nearly_full, more_than_1, more_than_0}
        add(1, 0, 32'hA,  32'hA,  4'b0001);
        add(1, 0, 32'hB,  32'hA,  4'b0011);
        add(1, 0, 32'hC,  32'hA,  4'b0011);
        add(0, 1, 32'h0,  32'hB,  4'b0011);
        add(0, 1, 32'h0,  32'hC,  4'b0001);
        add(0, 1, 32'h0,  32'hC,  4'b0000);
        add(1, 0, 32'h1,  32'h1,  4'b0001);
        add(1, 0, 32'h2,  32'h1,  4'b0011);
        add(1, 0, 32'h3,  32'h1,  4'b0011);
        add(1, 0, 32'h4,  32'h1,  4'b0111);
        add(1, 0, 32'h5,  32'h1,  4'b1111);
        add(1, 0, 32'h6,  32'h1,  4'b1111);
        add(1, 1, 32'h7,  32'h2,  4'b1111);
        add(0, 1, 32'h0,  32'h3,  4'b0111);
        add(0, 1, 32'h0,  32'h4,  4'b0011);
        add(0, 1, 32'h0,  32'h5,  4'b0011);
        add(0, 1, 32'h0,  32'h7,  4'b0001);
        add(0, 1, 32'h0,  32'h7,  4'b0000);
        add(0, 1, 32'h0,  32'h7,  4'b0000);
        add(1, 1, 32'h33, 32'h33, 4'b0001);
        add(0, 1, 32'h0,  32'h33, 4'b0000);
        add(1, 0, 32'h11, 32'h11, 4'b0001);
        add(1, 1, 32'h22, 32'h22, 4'b0001);
        add(0, 1, 32'h0,  32'h22, 4'b0000);

        for (int i = 0; i < n_vecs; i++) begin
            step(vecs[i].wr, vecs[i].rd, vecs[i].din);
            check($sformatf("vec%0d dout", i), dout, vecs[i].exp_dout);
            check($sformatf("vec%0d flags", i), {28'd0, w_flags}, {28'd0, vecs[i].exp_flags});
        end

        // Asynchronous reset in the middle of a cycle with three words queued.
        step(1, 0, 32'h41);
        step(1, 0, 32'h42);
        step(1, 0, 32'h43);
        check("pre-reset flags", {28'd0, w_flags}, {28'd0, 4'b0011});
        pulse_reset();
        step(1, 0, 32'h5A);
        check("post-reset write dout", dout, 32'h5A);
        check("post-reset write flags", {28'd0, w_flags}, {28'd0, 4'b0001});
        step(0, 1, 32'h0);
        check("post-reset drain flags", {28'd0, w_flags}, '0);

        // Streaming with the read one cycle behind the write wraps the pointers.
        sb.delete();
        for (int i = 0; i <= 20; i++) begin
            wr = (i < 20);
            rd = (i > 0);
            d  = 32'h100 + i;
            if (rd) begin
                if (sb.size() == 0) begin
                    check($sformatf("stream%0d scoreboard empty", i), 32'd1, 32'd0);
                end else begin
                    exp_v = sb.pop_front();
                    check($sformatf("stream%0d dout", i), dout, exp_v);
                end
            end
            if (wr) begin
                sb.push_back(d);
            end
            step(wr, rd, d);
            check($sformatf("stream%0d flags", i), {28'd0, w_flags},
                  {28'd0, 3'b000, (i < 20)});
        end
        check("stream scoreboard drained", 32'(sb.size()), 32'd0);

        // Random legal traffic against a queue model.
        pulse_reset();
        last_head = '0;
        for (int c = 0; c < 300; c++) begin
            wr = 1'($urandom_range(0, 1));
            rd = 1'($urandom_range(0, 1));
            d  = $urandom;
            sz = model_q.size();
            if (rd && sz == 0) rd = 1'b0;
            if (wr && sz == C_DEPTH && !rd) wr = 1'b0;
            eff_rd = rd && (sz > 0);
            eff_wr = wr && ((sz < C_DEPTH) || eff_rd);
            if (eff_rd) void'(model_q.pop_front());
            if (eff_wr) model_q.push_back(d);
            sz = model_q.size();
            if (sz > 0) last_head = model_q[0];
            step(wr, rd, d);
            check($sformatf("rand%0d dout", c), dout, last_head);
            check($sformatf("rand%0d flags", c), {28'd0, w_flags},
                  {28'd0, (sz == C_DEPTH), (sz >= C_DEPTH - 1), (sz >= 2), (sz >= 1)});
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
        $fatal(1);
    end

endmodule

`default_nettype wire
